// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch / memory-address stage in front of the CPU controller. It holds the
//   PC, the data address register and the IR, and sequences instruction
//   reads from a RAM whose read latency is RAM_LAT cycles (1..3). It also
//   decodes the IR fields and issues single-cycle data writes.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   fetch_req            level: fetch the instruction at pc
//   clear_pc             pc := RESET_PC, abort any in-flight fetch
//   load_addr            data_addr := dp_out[ADDR_W-1:0]
//   sel_addr             idle address source (1 = pc, 0 = data_addr)
//   mem_w_req            write dp_wdata at data_addr (idle only)
//   dp_out, dp_wdata     datapath address source / store data
//   ram_rdata            RAM read data, RAM_LAT cycles after the address
//   ram_addr, ram_wdata, ram_w_en   RAM interface
//   busy, fetch_done     fetch in flight / IR updated on the previous edge
//   pc, ir               architectural PC and instruction register
//   opcode..rm, sximm8, sximm5      IR field decode (combinational)
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                RAM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              clear_pc,
  input  logic              load_addr,
  input  logic              sel_addr,
  input  logic              mem_w_req,
  input  logic [DATA_W-1:0] dp_out,
  input  logic [DATA_W-1:0] dp_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_w_en,
  output logic              busy,
  output logic              fetch_done,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [2:0]        opcode,
  output logic [1:0]        alu_op,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [1:0]        shift_op,
  output logic [2:0]        rm,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_LATCH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                fetch_done_q, fetch_done_d;

  // Only the low ADDR_W bits of the datapath output form an address.
  logic unused_dp_hi;
  assign unused_dp_hi = ^dp_out[DATA_W-1:ADDR_W];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    fetch_done_d = 1'b0;
    data_addr_d  = load_addr ? dp_out[ADDR_W-1:0] : data_addr_q;
    ram_addr     = pc_q;
    ram_w_en     = 1'b0;
    busy         = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        // A write always targets data_addr, whatever sel_addr says.
        ram_addr = (sel_addr && !mem_w_req) ? pc_q : data_addr_q;
        if (mem_w_req)      ram_w_en = !clear_pc;
        else if (fetch_req) state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = 2'(RAM_LAT - 1);
        state_d = (RAM_LAT > 1) ? S_WAIT : S_LATCH;
      end
      S_WAIT: begin
        // One WAIT cycle per extra latency cycle beyond the first.
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = S_LATCH;
      end
      S_LATCH: begin
        ir_d         = ram_rdata;
        pc_d         = pc_q + 1'b1;
        fetch_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // clear_pc beats everything, including a fetch completing this edge.
    if (clear_pc) begin
      state_d      = S_IDLE;
      pc_d         = RESET_PC;
      ir_d         = ir_q;
      fetch_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      data_addr_q  <= '0;
      cnt_q        <= '0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      data_addr_q  <= data_addr_d;
      cnt_q        <= cnt_d;
      fetch_done_q <= fetch_done_d;
    end
  end

  assign ram_wdata  = dp_wdata;
  assign fetch_done = fetch_done_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[15:13];
  assign alu_op     = ir_q[12:11];
  assign rn         = ir_q[10:8];
  assign rd         = ir_q[7:5];
  assign shift_op   = ir_q[4:3];
  assign rm         = ir_q[2:0];
  assign sximm8     = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5     = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};

endmodule
